// File: rtl/usb_uart_bridge_fifo_ep.sv
`default_nettype none
// ============================================================================
// Module   : usb_uart_bridge_fifo_ep
// Brief    : Buffered USB bulk-endpoint <-> byte-stream bridge. The TX FIFO
//            feeds multi-byte IN packets. A short packet is flushed after
//            FLUSH_TIMEOUT idle cycles. The RX FIFO is filled from the OUT
//            endpoint one byte at a time.
// Option   : USB_UART_BRIDGE_ZLP_EN - when defined, a packet of exactly
//            MAX_PKT bytes that empties the TX FIFO is followed by a
//            zero-length packet.
// Revision : 1.0 - initial release
// ============================================================================
module usb_uart_bridge_fifo_ep #(
  parameter int TX_DEPTH      = 128,
  parameter int RX_DEPTH      = 64,
  parameter int MAX_PKT       = 64,
  parameter int FLUSH_TIMEOUT = 1000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        out_ep_req,
  input  logic                        out_ep_grant,
  input  logic                        out_ep_data_avail,
  input  logic                        out_ep_setup,
  output logic                        out_ep_data_get,
  input  logic [7:0]                  out_ep_data,
  output logic                        out_ep_stall,
  input  logic                        out_ep_acked,
  output logic                        in_ep_req,
  input  logic                        in_ep_grant,
  input  logic                        in_ep_data_free,
  output logic                        in_ep_data_put,
  output logic [7:0]                  in_ep_data,
  output logic                        in_ep_data_done,
  output logic                        in_ep_stall,
  input  logic                        in_ep_acked,
  input  logic                        uart_we,
  input  logic                        uart_re,
  input  logic [7:0]                  uart_di,
  output logic [7:0]                  uart_do,
  output logic                        uart_wait,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);
  localparam int c_tx_aw  = $clog2(TX_DEPTH);
  localparam int c_tx_lw  = c_tx_aw + 1;
  localparam int c_rx_aw  = $clog2(RX_DEPTH);
  localparam int c_rx_lw  = c_rx_aw + 1;
  localparam int c_cnt_w  = $clog2(MAX_PKT + 1);
  localparam int c_tmr_w  = $clog2(FLUSH_TIMEOUT + 1);

  localparam logic [c_tx_lw-1:0] c_tx_full_lvl = c_tx_lw'(TX_DEPTH);
  localparam logic [c_tx_lw-1:0] c_tx_pkt_lvl  = c_tx_lw'(MAX_PKT);
  localparam logic [c_rx_lw-1:0] c_rx_full_lvl = c_rx_lw'(RX_DEPTH);
  localparam logic [c_rx_lw-1:0] c_rx_room_lvl = c_rx_lw'(RX_DEPTH - 2);
  localparam logic [c_cnt_w-1:0] c_pkt_max     = c_cnt_w'(MAX_PKT);
  localparam logic [c_tmr_w-1:0] c_tmo         = c_tmr_w'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_GET, R_CAP} rx_state_t;
  typedef enum logic [2:0] {I_IDLE, I_REQ, I_PUT, I_DONE, I_GAP} in_state_t;

  rx_state_t rx_state_q, rx_state_d;
  in_state_t in_state_q, in_state_d;

  logic [7:0]         tx_mem [TX_DEPTH];
  logic [7:0]         rx_mem [RX_DEPTH];
  logic [c_tx_aw-1:0] tx_wptr_q, tx_rptr_q;
  logic [c_rx_aw-1:0] rx_wptr_q, rx_rptr_q;
  logic [c_tx_lw-1:0] tx_level_q;
  logic [c_rx_lw-1:0] rx_level_q;
  logic [c_cnt_w-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [c_tmr_w-1:0] tmr_q;
  logic [7:0]         uart_do_q, in_data_q;
  logic               in_put_q;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_rx_room;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_zlp_pend;
  logic unused_inputs;

  assign w_tx_full  = (tx_level_q == c_tx_full_lvl);
  assign w_tx_empty = (tx_level_q == '0);
  assign w_rx_full  = (rx_level_q == c_rx_full_lvl);
  assign w_rx_empty = (rx_level_q == '0);
  assign w_rx_room  = (rx_level_q <= c_rx_room_lvl);
  assign w_tx_push  = uart_we & ~w_tx_full;
  assign w_rx_pop   = uart_re & ~w_rx_empty;
  // RX FIFO is written at the end of R_GET, when the OUT byte is valid.
  assign w_rx_push  = (rx_state_q == R_GET) & ~w_rx_full;

  assign uart_wait     = (uart_we & w_tx_full) | (uart_re & w_rx_empty);
  assign uart_do       = uart_do_q;
  assign in_ep_data    = in_data_q;
  assign in_ep_data_put = in_put_q;
  assign tx_level      = tx_level_q;
  assign rx_level      = rx_level_q;
  assign out_ep_stall  = 1'b0;
  assign in_ep_stall   = 1'b0;
  assign unused_inputs = ^{out_ep_setup, out_ep_acked, in_ep_acked};

`ifdef USB_UART_BRIDGE_ZLP_EN
  logic zlp_q, zlp_d;
  // Remembers that a zero-length packet must follow the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) zlp_q <= 1'b0;
    else          zlp_q <= zlp_d;
  end
  assign w_zlp_pend = zlp_q;
`else
  assign w_zlp_pend = 1'b0;
`endif

  // FIFO storage; no reset needed because the levels gate every read.
  always_ff @(posedge clk) begin
    if (w_tx_push) tx_mem[tx_wptr_q] <= uart_di;
    if (w_rx_push) rx_mem[rx_wptr_q] <= out_ep_data;
  end

  // FIFO pointers, levels, UART read data and the registered IN byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_level_q <= '0;
      uart_do_q  <= '0;
      in_data_q  <= '0;
      in_put_q   <= 1'b0;
    end else begin
      if (w_tx_push) tx_wptr_q <= tx_wptr_q + c_tx_aw'(1);
      if (w_tx_pop)  tx_rptr_q <= tx_rptr_q + c_tx_aw'(1);
      if (w_rx_push) rx_wptr_q <= rx_wptr_q + c_rx_aw'(1);
      if (w_rx_pop)  rx_rptr_q <= rx_rptr_q + c_rx_aw'(1);
      if (w_tx_push && !w_tx_pop)      tx_level_q <= tx_level_q + c_tx_lw'(1);
      else if (!w_tx_push && w_tx_pop) tx_level_q <= tx_level_q - c_tx_lw'(1);
      if (w_rx_push && !w_rx_pop)      rx_level_q <= rx_level_q + c_rx_lw'(1);
      else if (!w_rx_push && w_rx_pop) rx_level_q <= rx_level_q - c_rx_lw'(1);
      if (w_rx_pop) uart_do_q <= rx_mem[rx_rptr_q];
      in_put_q <= w_tx_pop;
      if (w_tx_pop) in_data_q <= tx_mem[tx_rptr_q];
    end
  end

  // Idle-flush timer: counts while data waits in I_IDLE, restarts on writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             tmr_q <= '0;
    else if (w_tx_push || in_state_q != I_IDLE) tmr_q <= '0;
    else if (!w_tx_empty && tmr_q != c_tmo)     tmr_q <= tmr_q + c_tmr_w'(1);
  end

  // State registers for both endpoint FSMs and the packet byte counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= R_IDLE;
      in_state_q <= I_IDLE;
      pkt_cnt_q  <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      in_state_q <= in_state_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // OUT endpoint FSM: at most one outstanding get, room checked before each.
  always_comb begin
    rx_state_d      = rx_state_q;
    out_ep_req      = 1'b0;
    out_ep_data_get = 1'b0;
    case (rx_state_q)
      R_IDLE: if (out_ep_data_avail && w_rx_room) rx_state_d = R_REQ;
      R_REQ: begin
        out_ep_req = 1'b1;
        if (!out_ep_data_avail) begin
          rx_state_d = R_IDLE;
        end else if (out_ep_grant) begin
          out_ep_data_get = 1'b1;
          rx_state_d      = R_GET;
        end
      end
      R_GET: begin
        out_ep_req = 1'b1;
        rx_state_d = R_CAP;
      end
      R_CAP: begin
        out_ep_req = 1'b1;
        rx_state_d = (out_ep_data_avail && out_ep_grant && w_rx_room) ? R_REQ : R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // IN endpoint FSM: packetises the TX FIFO, ends with a one-cycle done.
  always_comb begin
    in_state_d      = in_state_q;
    pkt_cnt_d       = pkt_cnt_q;
    w_tx_pop        = 1'b0;
    in_ep_req       = 1'b0;
    in_ep_data_done = 1'b0;
`ifdef USB_UART_BRIDGE_ZLP_EN
    zlp_d           = zlp_q;
`endif
    case (in_state_q)
      I_IDLE: begin
        if (tx_level_q >= c_tx_pkt_lvl || (!w_tx_empty && tmr_q == c_tmo)) begin
          in_state_d = I_REQ;
          pkt_cnt_d  = '0;
        end
      end
      I_REQ: begin
        in_ep_req = 1'b1;
        if (in_ep_grant && in_ep_data_free) in_state_d = w_zlp_pend ? I_DONE : I_PUT;
      end
      I_PUT: begin
        in_ep_req = 1'b1;
        if (w_tx_empty || pkt_cnt_q == c_pkt_max) begin
          in_state_d = I_DONE;
        end else if (in_ep_data_free) begin
          w_tx_pop  = 1'b1;
          pkt_cnt_d = pkt_cnt_q + c_cnt_w'(1);
        end
      end
      I_DONE: begin
        in_ep_req       = 1'b1;
        in_ep_data_done = 1'b1;
        in_state_d      = I_GAP;
`ifdef USB_UART_BRIDGE_ZLP_EN
        zlp_d           = (pkt_cnt_q == c_pkt_max) && w_tx_empty;
`endif
      end
      I_GAP: begin
        in_state_d = I_IDLE;
        if (w_zlp_pend) begin
          in_state_d = I_REQ;
          pkt_cnt_d  = '0;
        end
      end
      default: in_state_d = I_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_uart_bridge_fifo_ep.sv
`default_nettype none
// Bench for usb_uart_bridge_fifo_ep: host-side IN/OUT endpoint models and a
// byte-queue reference for ordering, packet sizes and FIFO levels.
module tb_usb_uart_bridge_fifo_ep;
  localparam int TXD = 128;
  localparam int RXD = 64;
  localparam int MP  = 64;
  localparam int FT  = 16;
  localparam int LIM = 3000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       out_ep_req, out_ep_grant, out_ep_setup, out_ep_data_get, out_ep_stall, out_ep_acked;
  logic       out_ep_data_avail = 1'b0;
  logic [7:0] out_ep_data = 8'h00;
  logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put, in_ep_data_done;
  logic       in_ep_stall, in_ep_acked;
  logic [7:0] in_ep_data;
  logic       uart_we, uart_re, uart_wait;
  logic [7:0] uart_di, uart_do;
  logic [$clog2(TXD):0] tx_level;
  logic [$clog2(RXD):0] rx_level;

  always #5 clk = ~clk;
  assign in_ep_grant  = in_ep_req;
  assign out_ep_grant = out_ep_req;

  usb_uart_bridge_fifo_ep #(
    .TX_DEPTH(TXD), .RX_DEPTH(RXD), .MAX_PKT(MP), .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
    .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
    .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
    .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
    .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
    .uart_we(uart_we), .uart_re(uart_re), .uart_di(uart_di), .uart_do(uart_do),
    .uart_wait(uart_wait), .tx_level(tx_level), .rx_level(rx_level)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cur_pkt[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  logic [7:0] oexp[$];
  int         pkt_lens[$];
  int         done_cnt = 0;
  int         put_cnt  = 0;
  int         get_cnt  = 0;
  bit         out_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host IN side: collect put bytes, close a packet on each done pulse.
  always @(negedge clk) begin
    if (!reset_n) begin
      cur_pkt.delete();
    end else begin
      if (in_ep_data_put) begin
        cur_pkt.push_back(in_ep_data);
        got_q.push_back(in_ep_data);
        put_cnt++;
      end
      if (in_ep_data_done) begin
        pkt_lens.push_back(cur_pkt.size());
        cur_pkt.delete();
        done_cnt++;
      end
    end
  end

  // Host OUT side: a get is answered with the next byte during the following cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      out_pend = 1'b0;
    end else begin
      if (out_pend && out_q.size() != 0) out_ep_data = out_q.pop_front();
      out_pend = out_ep_data_get;
      if (out_ep_data_get) get_cnt++;
    end
    out_ep_data_avail = (out_q.size() != 0);
  end

  // Call right after a falling edge; returns at the falling edge after acceptance.
  task automatic uart_write(input logic [7:0] b);
    int t = 0;
    uart_we = 1'b1;
    uart_di = b;
    #1;
    while (uart_wait && t < LIM) begin @(negedge clk); #1; t++; end
    check("wr_timeout", t < LIM, 1);
    @(negedge clk);
    exp_q.push_back(b);
    uart_we = 1'b0;
  endtask

  task automatic uart_read(output logic [7:0] b);
    int t = 0;
    uart_re = 1'b1;
    #1;
    while (uart_wait && t < LIM) begin @(negedge clk); #1; t++; end
    check("rd_timeout", t < LIM, 1);
    @(negedge clk);
    uart_re = 1'b0;
    b = uart_do;
  endtask

  task automatic wait_done(input int n, input string tag);
    int t = 0;
    while (done_cnt < n && t < LIM) begin @(negedge clk); t++; end
    check(tag, done_cnt >= n, 1);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int d0, p0, t, sum;
    reset_n = 1'b0; uart_we = 1'b0; uart_re = 1'b0; uart_di = 8'h00;
    in_ep_data_free = 1'b1; out_ep_setup = 1'b0; out_ep_acked = 1'b0; in_ep_acked = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_req", out_ep_req, 0);
    check("rst_get", out_ep_data_get, 0);
    check("rst_in_req", in_ep_req, 0);
    check("rst_put", in_ep_data_put, 0);
    check("rst_in_data", in_ep_data, 0);
    check("rst_done", in_ep_data_done, 0);
    check("rst_uart_do", uart_do, 0);
    check("rst_wait", uart_wait, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_stalls", {out_ep_stall, in_ep_stall}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Short packet flushed by the idle timer.
    uart_write(8'h41); uart_write(8'h42); uart_write(8'h43);
    check("t1_level", tx_level, 3);
    repeat (FT) @(negedge clk);
    check("t1_req_early", in_ep_req, 0);
    @(negedge clk);
    check("t1_req_timeout", in_ep_req, 1);
    wait_done(1, "t1_done_to");
    repeat (4) @(negedge clk);
    check("t1_npkt", pkt_lens.size(), 1);
    if (pkt_lens.size() >= 1) check("t1_len", pkt_lens[0], 3);
    check("t1_level_end", tx_level, 0);
    check("t1_ndone", done_cnt, 1);
    cmp_stream("t1_byte");
    pkt_lens.delete();

    // Fill the TX FIFO while the host holds off, then drain 64/64/2.
    in_ep_data_free = 1'b0;
    for (int i = 0; i < TXD; i++) uart_write(8'($urandom));
    check("t2_full_level", tx_level, TXD);
    uart_we = 1'b1;
    uart_di = 8'($urandom);
    #1;
    check("t2_wait", uart_wait, 1);
    @(negedge clk);
    check("t2_hold_level", tx_level, TXD);
    in_ep_data_free = 1'b1;
    uart_write(uart_di);
    uart_write(8'($urandom));
    wait_done(4, "t2_done_to");
    repeat (4) @(negedge clk);
    check("t2_npkt", pkt_lens.size(), 3);
    if (pkt_lens.size() >= 3) begin
      check("t2_len0", pkt_lens[0], MP);
      check("t2_len1", pkt_lens[1], MP);
      check("t2_len2", pkt_lens[2], 2);
    end
    check("t2_level_end", tx_level, 0);
    cmp_stream("t2_byte");
    pkt_lens.delete();

    // OUT endpoint delivers 0x10..0x14, host reads them back to back.
    p0 = get_cnt;
    for (int i = 0; i < 5; i++) out_q.push_back(8'(8'h10 + i));
    t = 0;
    while (rx_level != 5 && t < LIM) begin @(negedge clk); t++; end
    check("t3_rx_level", rx_level, 5);
    repeat (8) @(negedge clk);
    check("t3_gets", get_cnt - p0, 5);
    check("t3_out_req_idle", out_ep_req, 0);
    for (int i = 0; i < 5; i++) begin
      uart_read(b);
      check("t3_do", b, 8'h10 + i);
    end
    uart_re = 1'b1;
    #1;
    check("t3_wait_empty", uart_wait, 1);
    check("t3_rx_level_end", rx_level, 0);
    @(negedge clk);
    uart_re = 1'b0;
    check("t3_do_hold", uart_do, 8'h14);

    // Random OUT bytes with random read spacing.
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      out_q.push_back(b);
      oexp.push_back(b);
    end
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      uart_read(b);
      check("t3r_do", b, oexp.pop_front());
    end

    // Host backpressure mid-packet.
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) uart_write(8'($urandom));
    t = 0;
    while (cur_pkt.size() < 3 && t < LIM) begin @(negedge clk); t++; end
    check("t4_start_to", t < LIM, 1);
    in_ep_data_free = 1'b0;
    #1;
    p0 = put_cnt;
    repeat (3) @(negedge clk);
    #1;
    check("t4_pause_puts", put_cnt - p0, 0);
    check("t4_req_held", in_ep_req, 1);
    in_ep_data_free = 1'b1;
    wait_done(d0 + 1, "t4_done_to");
    repeat (6) @(negedge clk);
    check("t4_ndone", done_cnt - d0, 1);
    if (pkt_lens.size() >= 1) check("t4_len", pkt_lens[0], 10);
    cmp_stream("t4_byte");
    pkt_lens.delete();

    // Reset in the middle of a packet.
    for (int i = 0; i < 20; i++) uart_write(8'($urandom));
    t = 0;
    while (cur_pkt.size() < 2 && t < LIM) begin @(negedge clk); t++; end
    check("t5_start_to", t < LIM, 1);
    reset_n = 1'b0;
    #1;
    check("t5_req", in_ep_req, 0);
    check("t5_put", in_ep_data_put, 0);
    check("t5_done", in_ep_data_done, 0);
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t5_tx_level", tx_level, 0);
    check("t5_rx_level", rx_level, 0);
    repeat (40) @(negedge clk);
    check("t5_no_done", done_cnt, d0);
    check("t5_req_idle", in_ep_req, 0);
    got_q.delete(); exp_q.delete(); pkt_lens.delete();

    // Exactly one full packet; zero-length follow-up only when enabled.
    d0 = done_cnt;
    for (int i = 0; i < MP; i++) uart_write(8'($urandom));
    wait_done(d0 + 1, "t6_done_to");
    repeat (60) @(negedge clk);
`ifdef USB_UART_BRIDGE_ZLP_EN
    check("t6_ndone", done_cnt - d0, 2);
    if (pkt_lens.size() >= 2) check("t6_zlp_len", pkt_lens[1], 0);
`else
    check("t6_ndone", done_cnt - d0, 1);
`endif
    if (pkt_lens.size() >= 1) check("t6_len", pkt_lens[0], MP);
    cmp_stream("t6_byte");
    pkt_lens.delete();

    // Random traffic with random host backpressure.
    for (int i = 0; i < 200; i++) begin
      in_ep_data_free = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      uart_write(8'($urandom));
    end
    in_ep_data_free = 1'b1;
    t = 0;
    while ((tx_level != 0 || in_ep_req) && t < LIM) begin @(negedge clk); t++; end
    check("t7_drain_to", t < LIM, 1);
    repeat (5) @(negedge clk);
    sum = 0;
    foreach (pkt_lens[i]) begin
      check("t7_len_max", pkt_lens[i] <= MP, 1);
      sum += pkt_lens[i];
    end
    check("t7_sum", sum, 200);
    cmp_stream("t7_byte");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/usb_uart_bridge_fifo_ep.md
Name: usb_uart_bridge_fifo_ep

Overview:
Buffered, parametrised USB bulk-endpoint ↔ byte-stream bridge. Replaces the single-byte-per-packet bridge with TX and RX FIFOs, multi-byte IN packets, and idle-timeout flush of short packets. Sits between the USB protocol engine's OUT/IN endpoint arbitration interface and a simple byte-wide UART-style host port.

Parameters:
TX_DEPTH, 128, TX FIFO depth in bytes; power of 2, ≥ MAX_PKT.
RX_DEPTH, 64, RX FIFO depth in bytes; power of 2, ≥ 4.
MAX_PKT, 64, maximum IN packet payload in bytes (1..64).
FLUSH_TIMEOUT, 1000, idle clk cycles before a partial IN packet is sent; must be ≥ 1.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
out_ep_req  out  1  request OUT endpoint access.
out_ep_grant  in  1  OUT endpoint granted.
out_ep_data_avail  in  1  OUT endpoint holds unread bytes.
out_ep_setup  in  1  setup-packet flag; ignored (bulk endpoint).
out_ep_data_get  out  1  pop one OUT byte.
out_ep_data  in  8  OUT byte; valid the cycle after out_ep_data_get.
out_ep_stall  out  1  tied 0.
out_ep_acked  in  1  unused.
in_ep_req  out  1  request IN endpoint access.
in_ep_grant  in  1  IN endpoint granted.
in_ep_data_free  in  1  IN buffer has room.
in_ep_data_put  out  1  push in_ep_data.
in_ep_data  out  8  IN byte, registered.
in_ep_data_done  out  1  one-cycle pulse: packet complete.
in_ep_stall  out  1  tied 0.
in_ep_acked  in  1  unused.
uart_we  in  1  write uart_di into TX FIFO.
uart_re  in  1  read one byte from RX FIFO.
uart_di  in  8  write data.
uart_do  out  8  read data; valid the cycle after an accepted uart_re.
uart_wait  out  1  combinational: (uart_we & tx_full) | (uart_re & rx_empty).
tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FIFOs empty, timer 0, both FSMs idle. Reset mid-packet abandons the packet: no in_ep_data_done is issued and in_ep_req drops immediately.
- UART side: uart_we & !tx_full pushes uart_di the same edge. uart_re & !rx_empty pops; uart_do updates next cycle and otherwise holds. While uart_wait=1 the request is not accepted, and the host holds it. we and re may coincide.
- RX FSM: R_IDLE → R_REQ when out_ep_data_avail & rx_level ≤ RX_DEPTH-2. out_ep_req=1 in R_REQ/R_GET/R_CAP.
  - R_REQ: on out_ep_grant & out_ep_data_avail, pulse out_ep_data_get (1 cycle) → R_GET.
  - R_GET → R_CAP: capture out_ep_data into the RX FIFO.
  - R_CAP: if avail & grant & room, go back to R_REQ; else R_IDLE.
  - Max 1 byte per 3 cycles; only one outstanding get. Overflow is impossible by the room check.
- Flush timer: increments each cycle while tx_level>0 and the IN FSM is in I_IDLE. Clears on any accepted uart_we or on leaving I_IDLE. Saturates at FLUSH_TIMEOUT.
- IN FSM: I_IDLE → I_REQ when tx_level ≥ MAX_PKT or (tx_level>0 & timer==FLUSH_TIMEOUT). Sets in_ep_req=1 and pkt_cnt=0.
  - I_REQ → I_PUT on in_ep_grant & in_ep_data_free.
  - I_PUT: each cycle with in_ep_data_free & TX nonempty & pkt_cnt<MAX_PKT: pop a byte, drive in_ep_data, pulse in_ep_data_put, pkt_cnt++. When pkt_cnt==MAX_PKT or TX empty → I_DONE. Bytes written during I_PUT may join the current packet. A deasserted in_ep_data_free stalls without leaving I_PUT.
  - I_DONE: in_ep_data_done=1 for one cycle, in_ep_req←0 → I_GAP.
  - I_GAP: one idle cycle → I_IDLE.
- Widths: levels are full-count (0..DEPTH inclusive); pointers wrap modulo DEPTH.

Optional Feature:
USB_UART_BRIDGE_ZLP_EN
- Defined: after a packet of exactly MAX_PKT bytes, if TX is empty at I_DONE, the FSM schedules a zero-length packet. It goes I_REQ → I_DONE with no puts and issues in_ep_data_done once more, terminating the host transfer.
- Undefined: no ZLP is issued; a full packet followed by empty TX simply returns to idle.

Test Plan:
- Write 0x41,0x42,0x43 then idle FLUSH_TIMEOUT=16 cycles → one IN packet with 3 puts (41,42,43) and one done pulse; tx_level returns to 0.
- Burst-write 130 bytes with MAX_PKT=64, TX_DEPTH=128 → uart_wait asserts once the FIFO holds 128. Output packets are 64, 64, then 2 after timeout; byte order is preserved.
- OUT endpoint supplies 5 bytes 0x10..0x14; uart_re each cycle → uart_do yields 10..14. uart_wait=1 on the 6th read, and out_ep_data_get pulses exactly 5 times.
- Toggle in_ep_data_free low for 3 cycles mid-packet → puts pause, packet stays contiguous, and exactly one done pulse follows.
- Assert reset_n=0 during I_PUT → in_ep_req, in_ep_data_put, and in_ep_data_done go 0 at once; after release, levels are 0 and no done pulse is issued.
- With USB_UART_BRIDGE_ZLP_EN defined, write exactly 64 bytes → a 64-byte packet followed by a zero-put packet (done pulse only). Without the macro, only the 64-byte packet is sent.
